// File: rtl/branch_unit_bp.sv
// Branch resolve + bimodal predictor: NextPCSrc/f_pred_taken combinational, flush/redirect_pc one cycle later, no backpressure.
// Optional BUNIT_PERF_EN adds branch_cnt/mispred_cnt event counters.
module branch_unit_bp #(
  parameter int XLEN        = 32,
  parameter int PC_W        = 32,
  parameter int BHT_ENTRIES = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [PC_W-1:0] f_pc,
  output logic            f_pred_taken,
  input  logic            ex_valid,
  input  logic [PC_W-1:0] ex_pc,
  input  logic [PC_W-1:0] ex_target,
  input  logic            ex_pred_taken,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic [4:0]      BUOp,
  output logic            NextPCSrc,
  output logic            flush,
  output logic [PC_W-1:0] redirect_pc
`ifdef BUNIT_PERF_EN
  ,
  output logic [31:0]     branch_cnt,
  output logic [31:0]     mispred_cnt
`endif
);

  localparam int IDX_W = $clog2(BHT_ENTRIES);

  logic [1:0]      bht_q [BHT_ENTRIES];
  logic [1:0]      bht_d [BHT_ENTRIES];
  logic            flush_q, flush_d;
  logic [PC_W-1:0] redirect_pc_q, redirect_pc_d;
  logic            taken;
  logic            is_cond;
  logic            is_jump;
  logic            eff_valid;
  logic            mispredict;
  logic [IDX_W-1:0] f_idx;
  logic [IDX_W-1:0] e_idx;
  logic            unused_pc_bits;

  assign f_idx = f_pc[IDX_W+1:2];
  assign e_idx = ex_pc[IDX_W+1:2];
  assign unused_pc_bits = ^{f_pc[PC_W-1:IDX_W+2], f_pc[1:0]};

  always_comb begin
    taken   = 1'b0;
    is_cond = 1'b0;
    is_jump = BUOp[4];
    if (BUOp[4]) begin
      taken = 1'b1;
    end else if (BUOp[3]) begin
      case (BUOp[2:0])
        3'b000: begin is_cond = 1'b1; taken = (rs1 == rs2); end
        3'b001: begin is_cond = 1'b1; taken = (rs1 != rs2); end
        3'b100: begin is_cond = 1'b1; taken = ($signed(rs1) <  $signed(rs2)); end
        3'b101: begin is_cond = 1'b1; taken = ($signed(rs1) >= $signed(rs2)); end
        3'b110: begin is_cond = 1'b1; taken = (rs1 <  rs2); end
        3'b111: begin is_cond = 1'b1; taken = (rs1 >= rs2); end
        default: begin is_cond = 1'b0; taken = 1'b0; end
      endcase
    end
  end

  // The instruction in EX during a flush cycle is wrong-path.
  assign eff_valid  = ex_valid & ~flush_q;
  assign mispredict = eff_valid & (taken != ex_pred_taken);

  always_comb begin
    bht_d = bht_q;
    if (eff_valid && is_cond) begin
      if (taken) begin
        if (bht_q[e_idx] != 2'b11) bht_d[e_idx] = bht_q[e_idx] + 2'd1;
      end else begin
        if (bht_q[e_idx] != 2'b00) bht_d[e_idx] = bht_q[e_idx] - 2'd1;
      end
    end
  end

  always_comb begin
    flush_d       = mispredict;
    redirect_pc_d = redirect_pc_q;
    if (mispredict) redirect_pc_d = taken ? ex_target : (ex_pc + PC_W'(4));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flush_q       <= 1'b0;
      redirect_pc_q <= '0;
      for (int i = 0; i < BHT_ENTRIES; i++) bht_q[i] <= 2'b01;
    end else begin
      flush_q       <= flush_d;
      redirect_pc_q <= redirect_pc_d;
      bht_q         <= bht_d;
    end
  end

  assign f_pred_taken = bht_q[f_idx][1];
  assign NextPCSrc    = taken;
  assign flush        = flush_q;
  assign redirect_pc  = redirect_pc_q;

`ifdef BUNIT_PERF_EN
  logic [31:0] branch_cnt_q, branch_cnt_d;
  logic [31:0] mispred_cnt_q, mispred_cnt_d;

  always_comb begin
    branch_cnt_d  = branch_cnt_q;
    mispred_cnt_d = mispred_cnt_q;
    if (eff_valid && (is_cond || is_jump)) branch_cnt_d = branch_cnt_q + 32'd1;
    if (mispredict) mispred_cnt_d = mispred_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      branch_cnt_q  <= branch_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  assign branch_cnt  = branch_cnt_q;
  assign mispred_cnt = mispred_cnt_q;
`endif

endmodule
